// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory boot loader between fetch, UART rx and imem
// Trailing checksum byte and CSUM state are present only when IMEM_CSUM_EN is defined.
module imem_boot_ctrl #(
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic [31:0]       cpu_addr,
   output logic [31:0]       cpu_instr,
   output logic              cpu_rst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic              load_busy,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_RUN  = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef IMEM_CSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                load_busy_q, load_busy_d;
   logic                load_err_q, load_err_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [23:0]         asm_q, asm_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
`ifdef IMEM_CSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic counting;
   logic timed_out;
   logic to_len;
   logic to_err;

   always_comb begin
      state_d     = state_q;
      cpu_rst_d   = cpu_rst_q;
      load_busy_d = load_busy_q;
      load_err_d  = load_err_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      wr_addr_d   = wr_addr_q;
      words_d     = words_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
`ifdef IMEM_CSUM_EN
      csum_d      = csum_q;
`endif
      to_len      = 1'b0;
      to_err      = 1'b0;

      counting = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef IMEM_CSUM_EN
                 || (state_q == S_CSUM)
`endif
                 ;
      // A byte arriving on the terminal count wins over the timeout.
      timed_out = counting && !rx_valid && (idle_q == IDLE_LAST);
      if (!counting || rx_valid) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + 1'b1;
      end

      case (state_q)
         S_RUN: begin
            if (rx_valid && rx_data == SYNC) to_len = 1'b1;
         end
         S_LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'd0 || {24'd0, rx_data} > DEPTH) begin
                  to_err = 1'b1;
               end else begin
                  len_d      = rx_data[ADDR_W:0];
                  words_d    = '0;
                  byte_cnt_d = 2'd0;
`ifdef IMEM_CSUM_EN
                  csum_d     = 8'd0;
`endif
                  state_d    = S_DATA;
               end
            end else if (timed_out) begin
               to_err = 1'b1;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
`ifdef IMEM_CSUM_EN
               csum_d = csum_q + rx_data;
`endif
               byte_cnt_d = byte_cnt_q + 1'b1;
               asm_d      = {rx_data, asm_q[23:8]};
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {rx_data, asm_q};
                  wr_addr_d   = words_q[ADDR_W-1:0];
                  words_d     = words_q + 1'b1;
                  if ((words_q + 1'b1) == len_q) begin
`ifdef IMEM_CSUM_EN
                     state_d = S_CSUM;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end else if (timed_out) begin
               to_err = 1'b1;
            end
         end
`ifdef IMEM_CSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum_q) state_d = S_DONE;
               else                   to_err  = 1'b1;
            end else if (timed_out) begin
               to_err = 1'b1;
            end
         end
`endif
         S_DONE: begin
            state_d     = S_RUN;
            cpu_rst_d   = 1'b0;
            load_busy_d = 1'b0;
         end
         S_HALT: begin
            if (rx_valid && rx_data == SYNC) begin
               load_err_d = 1'b0;
               to_len     = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase

      if (to_len) begin
         state_d     = S_LEN;
         cpu_rst_d   = 1'b1;
         load_busy_d = 1'b1;
      end
      if (to_err) begin
         state_d     = S_HALT;
         cpu_rst_d   = 1'b1;
         load_busy_d = 1'b0;
         load_err_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_RUN;
         cpu_rst_q   <= 1'b0;
         load_busy_q <= 1'b0;
         load_err_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         wr_addr_q   <= '0;
         words_q     <= '0;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         idle_q      <= '0;
`ifdef IMEM_CSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cpu_rst_q   <= cpu_rst_d;
         load_busy_q <= load_busy_d;
         load_err_q  <= load_err_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         wr_addr_q   <= wr_addr_d;
         words_q     <= words_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         idle_q      <= idle_d;
`ifdef IMEM_CSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Fetch sees memory only in RUN and only inside the implemented address window.
   assign cpu_instr = (state_q == S_RUN && cpu_addr[31:ADDR_W+2] == '0) ? mem_rdata : NOP;
   assign mem_addr  = (state_q == S_RUN) ? cpu_addr[ADDR_W+1:2] : wr_addr_q;

   assign cpu_rst      = cpu_rst_q;
   assign load_busy    = load_busy_q;
   assign load_err     = load_err_q;
   assign mem_we       = mem_we_q;
   assign mem_wdata    = mem_wdata_q;
   assign words_loaded = words_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[1:0];

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - scoreboard bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;
   localparam logic [31:0] NOP = 32'h00000013;

   logic              clk;
   logic              reset_n;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_instr;
   logic              cpu_rst;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic [31:0]       mem_rdata;
   logic              load_busy;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   logic [31:0] mem [DEPTH];
   logic [ADDR_W+31:0] exp_q [$];
   logic [ADDR_W+31:0] exp_item;
   logic [7:0] payload [$];
   logic [31:0] saved_word;
   int checks;
   int errors;

   imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_rst(cpu_rst),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .load_busy(load_busy), .load_err(load_err),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   always @(negedge clk) begin
      if (reset_n && mem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_we_unexpected: got addr %h data %h want no write", mem_addr, mem_wdata);
         end else begin
            exp_item = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== exp_item) begin
               errors++;
               $display("FAIL mem_write: got %h_%h want %h_%h", mem_addr, mem_wdata,
                        exp_item[ADDR_W+31:32], exp_item[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] n, input bit bad_csum);
      logic [7:0]  sum;
      logic [31:0] w;
      sum = 8'd0;
      w   = 32'd0;
      send_byte(8'hA5);
      checks++;
      if (cpu_rst !== 1'b1 || load_busy !== 1'b1 || load_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_flags: got rst %b busy %b err %b want 1 1 0", cpu_rst, load_busy, load_err);
      end
      send_byte(n);
      checks++;
      if (words_loaded !== '0) begin
         errors++;
         $display("FAIL len_clear: got %0d want 0", words_loaded);
      end
      for (int i = 0; i < payload.size(); i++) begin
         sum = sum + payload[i];
         w   = {payload[i], w[31:8]};
         if (i % 4 == 3) exp_q.push_back({ADDR_W'(i / 4), w});
         send_byte(payload[i]);
      end
`ifdef IMEM_CSUM_EN
      send_byte(bad_csum ? (sum ^ 8'h01) : sum);
`else
      if (bad_csum) sum = 8'd0;
`endif
   endtask

   task automatic test_reset;
      checks++;
      if (cpu_rst !== 1'b0 || load_busy !== 1'b0 || load_err !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got rst %b busy %b err %b we %b want 0 0 0 0", cpu_rst, load_busy, load_err, mem_we);
      end
      checks++;
      if (words_loaded !== '0 || mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_words: got %0d %h want 0 00000000", words_loaded, mem_wdata);
      end
      cpu_addr = 32'd4;
      #1;
      checks++;
      if (cpu_instr !== 32'h10000001) begin
         errors++;
         $display("FAIL reset_fetch: got %h want 10000001", cpu_instr);
      end
   endtask

   task automatic test_good_load;
      payload = '{8'hb7, 8'h07, 8'h00, 8'h40, 8'h13, 8'h07, 8'hf0, 8'h0f, 8'h23, 8'ha0, 8'he7, 8'h00};
      send_frame(8'd3, 1'b0);
      checks++;
      if (cpu_rst !== 1'b1 || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL done_cycle: got rst %b busy %b want 1 1", cpu_rst, load_busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (cpu_rst !== 1'b0 || load_busy !== 1'b0 || load_err !== 1'b0 || words_loaded !== 7'd3) begin
         errors++;
         $display("FAIL good_end: got rst %b busy %b err %b words %0d want 0 0 0 3", cpu_rst, load_busy, load_err, words_loaded);
      end
      cpu_addr = 32'd0;
      #1;
      checks++;
      if (cpu_instr !== 32'h400007b7) begin
         errors++;
         $display("FAIL good_fetch0: got %h want 400007b7", cpu_instr);
      end
      cpu_addr = 32'd8;
      #1;
      checks++;
      if (cpu_instr !== 32'h00e7a023) begin
         errors++;
         $display("FAIL good_fetch2: got %h want 00e7a023", cpu_instr);
      end
   endtask

   task automatic test_bad_csum;
      payload = '{8'hb7, 8'h07, 8'h00, 8'h40, 8'h13, 8'h07, 8'hf0, 8'h0f, 8'h23, 8'ha0, 8'he7, 8'h00};
      send_frame(8'd3, 1'b1);
      @(posedge clk);
      #1;
      cpu_addr = 32'd0;
      #1;
      checks++;
      if (cpu_rst !== 1'b1 || load_err !== 1'b1 || load_busy !== 1'b0 || cpu_instr !== NOP) begin
         errors++;
         $display("FAIL bad_csum: got rst %b err %b busy %b instr %h want 1 1 0 00000013", cpu_rst, load_err, load_busy, cpu_instr);
      end
   endtask

   task automatic test_bad_length;
      logic [ADDR_W:0] prev_words;
      prev_words = words_loaded;
      send_byte(8'hA5);
      send_byte(8'h00);
      checks++;
      if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_busy !== 1'b0 || words_loaded !== prev_words) begin
         errors++;
         $display("FAIL len_zero: got err %b rst %b busy %b words %0d want 1 1 0 %0d", load_err, cpu_rst, load_busy, words_loaded, prev_words);
      end
      send_byte(8'hA5);
      checks++;
      if (load_err !== 1'b0 || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL halt_resync: got err %b busy %b want 0 1", load_err, load_busy);
      end
      send_byte(8'h41);
      cpu_addr = 32'd0;
      #1;
      checks++;
      if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_busy !== 1'b0 || cpu_instr !== NOP) begin
         errors++;
         $display("FAIL len_over: got err %b rst %b busy %b instr %h want 1 1 0 00000013", load_err, cpu_rst, load_busy, cpu_instr);
      end
   endtask

   task automatic test_recovery;
      payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_frame(8'd2, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (load_err !== 1'b0 || cpu_rst !== 1'b0 || words_loaded !== 7'd2) begin
         errors++;
         $display("FAIL recover: got err %b rst %b words %0d want 0 0 2", load_err, cpu_rst, words_loaded);
      end
      cpu_addr = 32'd4;
      #1;
      checks++;
      if (cpu_instr !== 32'h88776655) begin
         errors++;
         $display("FAIL recover_fetch: got %h want 88776655", cpu_instr);
      end
      send_byte(8'h55);
      checks++;
      if (cpu_rst !== 1'b0 || load_busy !== 1'b0) begin
         errors++;
         $display("FAIL run_ignore: got rst %b busy %b want 0 0", cpu_rst, load_busy);
      end
      cpu_addr = 32'h00000100;
      #1;
      checks++;
      if (cpu_instr !== NOP) begin
         errors++;
         $display("FAIL out_of_range: got %h want 00000013", cpu_instr);
      end
   endtask

   task automatic test_timeout;
      send_byte(8'hA5);
      send_byte(8'h02);
      exp_q.push_back({ADDR_W'(0), 32'hdeadbeef});
      send_byte(8'hef);
      send_byte(8'hbe);
      send_byte(8'had);
      send_byte(8'hde);
      repeat (99) @(posedge clk);
      #1;
      send_byte(8'h01);
      checks++;
      if (load_busy !== 1'b1 || load_err !== 1'b0) begin
         errors++;
         $display("FAIL byte_wins: got busy %b err %b want 1 0", load_busy, load_err);
      end
      repeat (99) @(posedge clk);
      #1;
      checks++;
      if (load_busy !== 1'b1 || load_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got busy %b err %b want 1 0", load_busy, load_err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (load_busy !== 1'b0 || load_err !== 1'b1 || cpu_rst !== 1'b1 || words_loaded !== 7'd1) begin
         errors++;
         $display("FAIL timeout: got busy %b err %b rst %b words %0d want 0 1 1 1", load_busy, load_err, cpu_rst, words_loaded);
      end
   endtask

   task automatic test_async_reset;
      saved_word = 32'hcafef00d;
      send_byte(8'hA5);
      send_byte(8'h02);
      exp_q.push_back({ADDR_W'(0), saved_word});
      send_byte(8'h0d);
      send_byte(8'hf0);
      send_byte(8'hfe);
      send_byte(8'hca);
      send_byte(8'h99);
      send_byte(8'h98);
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (cpu_rst !== 1'b0 || load_busy !== 1'b0 || words_loaded !== '0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got rst %b busy %b words %0d we %b want 0 0 0 0", cpu_rst, load_busy, words_loaded, mem_we);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cpu_addr = 32'd0;
      #1;
      checks++;
      if (cpu_instr !== saved_word || load_err !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_fetch: got %h err %b want %h 0", cpu_instr, load_err, saved_word);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      rx_data  = 8'd0;
      rx_valid = 1'b0;
      cpu_addr = 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h10000000 + i;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_good_load;
`ifdef IMEM_CSUM_EN
      test_bad_csum;
`endif
      test_bad_length;
      test_recovery;
      test_timeout;
      test_async_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_writes: got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
